// File: rtl/sensor_frame_sched.sv
// Telemetry frame scheduler: walks the sensor register map and streams framed bytes.
// Define SENSOR_FRAME_CKSUM_EN to append a trailing checksum byte to every frame.
module sensor_frame_sched #(
    parameter int         FIRST_ADDR = 1,
    parameter int         LAST_ADDR  = 23,
    parameter int         PERIOD     = 50000,
    parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       trig,
    output logic [7:0] addr,
    input  logic [7:0] data,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    localparam logic [7:0] FA    = 8'(FIRST_ADDR);
    localparam logic [7:0] LA    = 8'(LAST_ADDR);
    localparam logic [7:0] LEN_N = 8'(LAST_ADDR - FIRST_ADDR + 1);
    localparam int         TW    = (PERIOD > 2) ? $clog2(PERIOD) : 1;
    localparam logic [TW-1:0] TMAX = TW'(PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LEN,
        PAYLOAD,
`ifdef SENSOR_FRAME_CKSUM_EN
        CKSUM,
`endif
        DONE
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic          pending, pending_n;
    logic [7:0]    addr_n;
    logic [7:0]    tx_data_n;
    logic          tx_valid_n;
    logic          busy_n;
    logic          frame_done_n;
    logic          overrun_n;
`ifdef SENSOR_FRAME_CKSUM_EN
    logic [7:0]    cksum, cksum_n;
`endif

    logic wrap;
    logic req;
    logic load;

    assign wrap = enable && (timer == TMAX);
    assign req  = trig || wrap;
    // A new byte may be staged when the output slot is empty or being drained
    assign load = !tx_valid || tx_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            timer      <= '0;
            pending    <= 1'b0;
            addr       <= 8'h00;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
`ifdef SENSOR_FRAME_CKSUM_EN
            cksum      <= 8'h00;
`endif
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            pending    <= pending_n;
            addr       <= addr_n;
            tx_data    <= tx_data_n;
            tx_valid   <= tx_valid_n;
            busy       <= busy_n;
            frame_done <= frame_done_n;
            overrun    <= overrun_n;
`ifdef SENSOR_FRAME_CKSUM_EN
            cksum      <= cksum_n;
`endif
        end
    end

    always_comb begin
        state_n      = state;
        timer_n      = timer;
        pending_n    = pending || req;
        addr_n       = addr;
        tx_data_n    = tx_data;
        tx_valid_n   = tx_valid;
        busy_n       = busy;
        frame_done_n = 1'b0;
        overrun_n    = req && pending && (state != IDLE);
`ifdef SENSOR_FRAME_CKSUM_EN
        cksum_n      = cksum;
`endif

        if (!enable || wrap) begin
            timer_n = '0;
        end else begin
            timer_n = timer + 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (pending) begin
                    // Consuming the pending slot lets a same-cycle request refill it
                    pending_n = req;
                    busy_n    = 1'b1;
                    state_n   = SYNC;
                end
            end
            SYNC: begin
                if (load) begin
                    tx_data_n  = SYNC_BYTE;
                    tx_valid_n = 1'b1;
                    addr_n     = FA;
                    state_n    = LEN;
                end
            end
            LEN: begin
                if (load) begin
                    tx_data_n  = LEN_N;
                    tx_valid_n = 1'b1;
`ifdef SENSOR_FRAME_CKSUM_EN
                    cksum_n    = LEN_N;
`endif
                    state_n    = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (load) begin
                    tx_data_n  = data;
                    tx_valid_n = 1'b1;
`ifdef SENSOR_FRAME_CKSUM_EN
                    cksum_n    = cksum + data;
`endif
                    if (addr == LA) begin
`ifdef SENSOR_FRAME_CKSUM_EN
                        state_n = CKSUM;
`else
                        state_n = DONE;
`endif
                    end else begin
                        addr_n = addr + 8'd1;
                    end
                end
            end
`ifdef SENSOR_FRAME_CKSUM_EN
            CKSUM: begin
                if (load) begin
                    tx_data_n  = cksum;
                    tx_valid_n = 1'b1;
                    state_n    = DONE;
                end
            end
`endif
            DONE: begin
                if (tx_valid && tx_ready) begin
                    tx_valid_n   = 1'b0;
                    addr_n       = 8'h00;
                    busy_n       = 1'b0;
                    frame_done_n = 1'b1;
                    state_n      = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sensor_frame_sched.sv
// Scoreboard bench for sensor_frame_sched: random register maps and handshake patterns.
// Expected frames come from a byte-list model of the framing rules.
module tb_sensor_frame_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       trig = 1'b0;
    logic       tx_ready = 1'b0;
    logic [7:0] addr, data, tx_data;
    logic       tx_valid, busy, frame_done, overrun;

    logic       trig2 = 1'b0;
    logic       enable2 = 1'b0;
    logic       tx_ready2 = 1'b1;
    logic [7:0] data2 = 8'h3C;
    logic [7:0] addr2, tx_data2;
    logic       tx_valid2, busy2, frame_done2, overrun2;

    logic [7:0] mem [256];
    assign data = mem[addr];

    always #5 clk = ~clk;

    sensor_frame_sched #(
        .FIRST_ADDR(1), .LAST_ADDR(23), .PERIOD(100), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .trig(trig),
        .addr(addr), .data(data), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done),
        .overrun(overrun)
    );

    sensor_frame_sched #(
        .FIRST_ADDR(4), .LAST_ADDR(4), .PERIOD(100), .SYNC_BYTE(8'hA5)
    ) dut2 (
        .clk(clk), .rst(rst), .enable(enable2), .trig(trig2),
        .addr(addr2), .data(data2), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .busy(busy2), .frame_done(frame_done2),
        .overrun(overrun2)
    );

    int passed = 0;
    int total = 0;
    int ready_mode = 3;
    bit mon_en = 1'b0;
    int done_cnt = 0;
    int ovr_cnt = 0;
    int acc_cnt = 0;
    int cyc = 0;
    int done_cyc[$];
    logic [7:0] exp_q[$];
    logic [7:0] q2[$];
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: sync, length, every register byte in order, then the byte-sum
    task automatic push_frame();
        logic [7:0] s;
        s = 8'd23;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'd23);
        for (int a = 1; a <= 23; a++) begin
            exp_q.push_back(mem[a]);
            s = s + mem[a];
        end
`ifdef SENSOR_FRAME_CKSUM_EN
        exp_q.push_back(s);
`endif
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    endtask

    task automatic wait_frames(int target, int budget);
        for (int k = 0; k < budget && done_cnt < target; k++) tick();
        check("frame_timeout", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic pulse_trig();
        trig = 1'b1;
        tick();
        trig = 1'b0;
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: tx_ready = 1'b1;
            1: tx_ready = ~tx_ready;
            2: tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (frame_done) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
        if (overrun) ovr_cnt++;
        if (tx_valid && tx_ready) acc_cnt++;
        if (!mon_en) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid) check("busy_with_valid", 32'(busy), 32'd1);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_byte", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", 32'(tx_data), 32'(e));
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    always @(negedge clk) begin
        if (tx_valid2 && tx_ready2) q2.push_back(tx_data2);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int base_acc;
        logic [7:0] e2[$];
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);

        repeat (3) tick();
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b1;
        ready_mode = 0;
        repeat (2) tick();
        mon_en = 1'b1;

        push_frame();
        pulse_trig();
        check("lat_idle", 32'(tx_valid), 32'd0);
        tick();
        check("lat_busy", 32'(busy), 32'd1);
        check("lat_e2", 32'(tx_valid), 32'd0);
        tick();
        check("lat_e3", 32'(tx_valid), 32'd1);
        check("lat_sync", 32'(tx_data), 32'hA5);
        wait_frames(1, 200);
        tick();
        check("post_busy", 32'(busy), 32'd0);
        check("post_addr", 32'(addr), 32'd0);
        check("post_valid", 32'(tx_valid), 32'd0);

        base = 1;
        for (int k = 1; k <= 5; k++) begin
            ready_mode = k % 3;
            randomize_mem();
            push_frame();
            pulse_trig();
            base++;
            if (k == 3) begin
                push_frame();
                repeat (10) tick();
                pulse_trig();
                base++;
            end
            wait_frames(base, 600);
        end
        check("trig_overrun", 32'(ovr_cnt), 32'd0);
        check("trig_queue", 32'(exp_q.size()), 32'd0);

        ready_mode = 0;
        randomize_mem();
        repeat (2) tick();
        base = done_cnt;
        repeat (3) push_frame();
        enable = 1'b1;
        wait_frames(base + 3, 400);
        enable = 1'b0;
        check("period_1", 32'(done_cyc[base + 1] - done_cyc[base]), 32'd100);
        check("period_2", 32'(done_cyc[base + 2] - done_cyc[base + 1]), 32'd100);
        check("period_overrun", 32'(ovr_cnt), 32'd0);
        repeat (150) tick();
        check("period_stop", 32'(done_cnt), 32'(base + 3));

        ready_mode = 3;
        repeat (2) tick();
        base = done_cnt;
        repeat (2) push_frame();
        enable = 1'b1;
        repeat (350) tick();
        enable = 1'b0;
        check("stall_overrun", 32'(ovr_cnt), 32'd1);
        check("stall_hold_valid", 32'(tx_valid), 32'd1);
        check("stall_hold_sync", 32'(tx_data), 32'hA5);
        ready_mode = 0;
        wait_frames(base + 2, 300);
        repeat (150) tick();
        check("stall_frames", 32'(done_cnt), 32'(base + 2));
        check("stall_queue", 32'(exp_q.size()), 32'd0);

        mon_en = 1'b0;
        randomize_mem();
        base = done_cnt;
        base_acc = acc_cnt;
        pulse_trig();
        for (int k = 0; k < 100 && acc_cnt < base_acc + 7; k++) tick();
        check("abort_reach", 32'(acc_cnt >= base_acc + 7), 32'd1);
        rst = 1'b0;
        #1;
        check("abort_valid", 32'(tx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_addr", 32'(addr), 32'd0);
        check("abort_data", 32'(tx_data), 32'd0);
        repeat (3) tick();
        check("abort_no_done", 32'(done_cnt), 32'(base));
        rst = 1'b1;
        repeat (2) tick();
        mon_en = 1'b1;
        push_frame();
        pulse_trig();
        wait_frames(base + 1, 200);

        e2.push_back(8'hA5);
        e2.push_back(8'h01);
        e2.push_back(8'h3C);
`ifdef SENSOR_FRAME_CKSUM_EN
        e2.push_back(8'h3D);
`endif
        trig2 = 1'b1;
        tick();
        trig2 = 1'b0;
        repeat (20) tick();
        check("single_len", 32'(q2.size()), 32'(e2.size()));
        for (int i = 0; i < e2.size() && i < q2.size(); i++)
            check("single_byte", 32'(q2[i]), 32'(e2[i]));
        check("single_idle", 32'({busy2, overrun2, frame_done2, tx_valid2}), 32'd0);
        check("single_addr", 32'(addr2), 32'd0);

        repeat (5) tick();
        check("final_queue", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
